// File: rtl/glitch_sweep_sequencer.sv
// Glitch sweep sequencer: walks a (delay, width) grid with repeats, firing the glitch engine once per attempt.
// Optional macro SWEEP_STOP_ON_HIT_EN: a hit seen in WAIT_DONE/SETTLE ends the sweep at the hitting point.
module glitch_sweep_sequencer #(
  parameter int SETTLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [15:0]         delay_start_i,
  input  logic [15:0]         delay_stop_i,
  input  logic [7:0]          delay_step_i,
  input  logic [7:0]          width_start_i,
  input  logic [7:0]          width_stop_i,
  input  logic [7:0]          width_step_i,
  input  logic [7:0]          repeats_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic                engine_busy_i,
  input  logic                hit_i,
  output logic [15:0]         delay_o,
  output logic [7:0]          width_o,
  output logic                fire_o,
  output logic                running_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [23:0]         attempts_o
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, SETTLE, ADVANCE
  } state_t;

  state_t state_q, state_d;

  logic [15:0]         dstart_q, dstart_d, dstop_q, dstop_d;
  logic [7:0]          dstep_q, dstep_d;
  logic [7:0]          wstart_q, wstart_d, wstop_q, wstop_d, wstep_q, wstep_d;
  logic [7:0]          reps_q, reps_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  logic [15:0]         delay_q, delay_d;
  logic [7:0]          width_q, width_d;
  logic                done_q, done_d, timeout_q, timeout_d;
  logic [23:0]         attempts_q, attempts_d;
  logic [7:0]          rep_cnt_q, rep_cnt_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;

  logic [7:0]  dstep_eff, wstep_eff, reps_eff;
  logic [16:0] delay_sum;
  logic [8:0]  width_sum;

`ifndef SWEEP_STOP_ON_HIT_EN
  logic unused_hit;
  assign unused_hit = hit_i;
`endif

  // Zero step/repeat values are treated as 1; sums are one bit wider so overflow reads as "past stop".
  assign dstep_eff = (dstep_q == '0) ? 8'd1 : dstep_q;
  assign wstep_eff = (wstep_q == '0) ? 8'd1 : wstep_q;
  assign reps_eff  = (reps_q  == '0) ? 8'd1 : reps_q;
  assign delay_sum = {1'b0, delay_q} + {9'd0, dstep_eff};
  assign width_sum = {1'b0, width_q} + {1'b0, wstep_eff};

  always_comb begin
    state_d      = state_q;
    dstart_d     = dstart_q;
    dstop_d      = dstop_q;
    dstep_d      = dstep_q;
    wstart_d     = wstart_q;
    wstop_d      = wstop_q;
    wstep_d      = wstep_q;
    reps_d       = reps_q;
    settle_d     = settle_q;
    delay_d      = delay_q;
    width_d      = width_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    attempts_d   = attempts_q;
    rep_cnt_d    = rep_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          dstart_d   = delay_start_i;
          dstop_d    = delay_stop_i;
          dstep_d    = delay_step_i;
          wstart_d   = width_start_i;
          wstop_d    = width_stop_i;
          wstep_d    = width_step_i;
          reps_d     = repeats_i;
          settle_d   = settle_i;
          delay_d    = delay_start_i;
          width_d    = width_start_i;
          attempts_d = '0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          rep_cnt_d  = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (attempts_q != '1) attempts_d = attempts_q + 24'd1;
        wait_cnt_d = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (engine_busy_i) begin
          state_d = WAIT_DONE;
        end else if (wait_cnt_q == 3'd7) begin
          timeout_d    = 1'b1;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (!engine_busy_i) begin
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q >= settle_q) state_d = ADVANCE;
        else settle_cnt_d = settle_cnt_q + 1'b1;
      end
      ADVANCE: begin
        if ({1'b0, rep_cnt_q} + 9'd1 < {1'b0, reps_eff}) begin
          rep_cnt_d = rep_cnt_q + 8'd1;
          state_d   = ISSUE;
        end else begin
          rep_cnt_d = '0;
          if (delay_sum > {1'b0, dstop_q}) begin
            // Exhaustion leaves delay/width at the last point issued.
            if (width_sum > {1'b0, wstop_q}) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              delay_d = dstart_q;
              width_d = width_sum[7:0];
              state_d = ISSUE;
            end
          end else begin
            delay_d = delay_sum[15:0];
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SWEEP_STOP_ON_HIT_EN
    if (hit_i && (state_q == WAIT_DONE || state_q == SETTLE)) begin
      done_d  = 1'b1;
      state_d = IDLE;
    end
`endif

    if (abort_i && state_q != IDLE) begin
      done_d  = done_q;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dstart_q     <= '0;
      dstop_q      <= '0;
      dstep_q      <= '0;
      wstart_q     <= '0;
      wstop_q      <= '0;
      wstep_q      <= '0;
      reps_q       <= '0;
      settle_q     <= '0;
      delay_q      <= '0;
      width_q      <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      attempts_q   <= '0;
      rep_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      dstart_q     <= dstart_d;
      dstop_q      <= dstop_d;
      dstep_q      <= dstep_d;
      wstart_q     <= wstart_d;
      wstop_q      <= wstop_d;
      wstep_q      <= wstep_d;
      reps_q       <= reps_d;
      settle_q     <= settle_d;
      delay_q      <= delay_d;
      width_q      <= width_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      attempts_q   <= attempts_d;
      rep_cnt_q    <= rep_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign delay_o    = delay_q;
  assign width_o    = width_q;
  assign fire_o     = (state_q == ISSUE);
  assign running_o  = (state_q != IDLE);
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;
  assign attempts_o = attempts_q;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Directed bench for glitch_sweep_sequencer with a simple 5-cycle-busy engine model.
module tb_glitch_sweep_sequencer;
  logic        clk = 1'b0;
  logic        rst, start_i, abort_i, engine_busy_i, hit_i;
  logic [15:0] delay_start_i, delay_stop_i;
  logic [7:0]  delay_step_i, width_start_i, width_stop_i, width_step_i, repeats_i;
  logic [15:0] settle_i;
  logic [15:0] delay_o;
  logic [7:0]  width_o;
  logic        fire_o, running_o, done_o, timeout_o;
  logic [23:0] attempts_o;

  int tests = 0;
  int fails = 0;

  glitch_sweep_sequencer #(.SETTLE_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .delay_start_i(delay_start_i), .delay_stop_i(delay_stop_i), .delay_step_i(delay_step_i),
    .width_start_i(width_start_i), .width_stop_i(width_stop_i), .width_step_i(width_step_i),
    .repeats_i(repeats_i), .settle_i(settle_i), .engine_busy_i(engine_busy_i), .hit_i(hit_i),
    .delay_o(delay_o), .width_o(width_o), .fire_o(fire_o), .running_o(running_o),
    .done_o(done_o), .timeout_o(timeout_o), .attempts_o(attempts_o)
  );

  always #5 clk = ~clk;

  // Engine model: a fire pulse makes busy high for the following 5 cycles.
  logic   eng_en = 1'b1;
  int     eng_cnt = 0;
  always @(posedge clk) begin
    if (eng_en && fire_o) eng_cnt <= 5;
    else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
  end
  assign engine_busy_i = (eng_cnt != 0);

  // Fire log sampled on the falling edge.
  logic [15:0] log_d [0:255];
  logic [7:0]  log_w [0:255];
  int fire_cnt = 0;
  always @(negedge clk) begin
    if (fire_o === 1'b1) begin
      log_d[fire_cnt[7:0]] <= delay_o;
      log_w[fire_cnt[7:0]] <= width_o;
      fire_cnt <= fire_cnt + 1;
    end
  end

  task automatic set_cfg(input logic [15:0] ds, input logic [15:0] de, input logic [7:0] dst,
                         input logic [7:0] ws, input logic [7:0] we, input logic [7:0] wst,
                         input logic [7:0] rp, input logic [15:0] st);
    delay_start_i = ds; delay_stop_i = de; delay_step_i = dst;
    width_start_i = ws; width_stop_i = we; width_step_i = wst;
    repeats_i = rp; settle_i = st;
  endtask

  task automatic pulse_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (running_o === 1'b1 && n < budget) begin @(negedge clk); n++; end
    tests++;
    if (running_o !== 1'b0) begin
      fails++; $display("FAIL %s: sweep still running after %0d cycles", name, budget);
    end
    @(negedge clk);
  endtask

  task automatic wait_fire(input string name);
    int n = 0;
    while (fire_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (fire_o !== 1'b1) begin fails++; $display("FAIL %s: no fire_o within budget", name); end
  endtask

  task automatic check_grid(input string name, input int base);
    logic [15:0] ed [0:5];
    ed[0] = 16'd10; ed[1] = 16'd10; ed[2] = 16'd20; ed[3] = 16'd20; ed[4] = 16'd30; ed[5] = 16'd30;
    tests++;
    if (fire_cnt - base !== 12) begin
      fails++; $display("FAIL %s_fires: got %0d, expected 12", name, fire_cnt - base);
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (log_d[(base + i) % 256] !== ed[i % 6] || log_w[(base + i) % 256] !== ((i < 6) ? 8'd2 : 8'd3)) begin
        fails++;
        $display("FAIL %s_point%0d: got (%0d,%0d), expected (%0d,%0d)", name, i,
                 log_d[(base + i) % 256], log_w[(base + i) % 256], ed[i % 6], (i < 6) ? 2 : 3);
      end
    end
    tests++;
    if (attempts_o !== 24'd12 || done_o !== 1'b1 || timeout_o !== 1'b0) begin
      fails++; $display("FAIL %s_status: attempts=%0d done=%b timeout=%b, expected 12/1/0",
                        name, attempts_o, done_o, timeout_o);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    tests++;
    if (delay_o !== 16'd0 || width_o !== 8'd0 || fire_o !== 1'b0 || running_o !== 1'b0 ||
        done_o !== 1'b0 || timeout_o !== 1'b0 || attempts_o !== 24'd0) begin
      fails++;
      $display("FAIL %s: delay=%0d width=%0d fire=%b run=%b done=%b to=%b att=%0d, expected all 0",
               name, delay_o, width_o, fire_o, running_o, done_o, timeout_o, attempts_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; hit_i = 1'b0;
    set_cfg(16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
  endtask

  task automatic test_basic_sweep();
    int base = fire_cnt;
    set_cfg(16'd10, 16'd30, 8'd10, 8'd2, 8'd3, 8'd1, 8'd2, 16'd3);
    pulse_start();
    // Scramble the live config and re-request start; the sweep must not notice.
    set_cfg(16'd0, 16'd1000, 8'd1, 8'd9, 8'd9, 8'd1, 8'd7, 16'd0);
    repeat (4) @(negedge clk);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    wait_idle("basic", 2000);
    check_grid("basic", base);
  endtask

  task automatic test_zero_cfg();
    int base = fire_cnt;
    set_cfg(16'd5, 16'd7, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 16'd0);
    pulse_start();
    wait_idle("zero_cfg", 500);
    tests++;
    if (fire_cnt - base !== 3 || log_d[base % 256] !== 16'd5 || log_d[(base + 1) % 256] !== 16'd6 ||
        log_d[(base + 2) % 256] !== 16'd7 || attempts_o !== 24'd3) begin
      fails++; $display("FAIL zero_step: fires=%0d attempts=%0d, expected 3 fires at 5,6,7",
                        fire_cnt - base, attempts_o);
    end
    base = fire_cnt;
    set_cfg(16'd40, 16'd30, 8'd3, 8'd3, 8'd4, 8'd0, 8'd1, 16'd0);
    pulse_start();
    wait_idle("inverted", 500);
    tests++;
    if (fire_cnt - base !== 2 || log_d[base % 256] !== 16'd40 || log_w[base % 256] !== 8'd3 ||
        log_d[(base + 1) % 256] !== 16'd40 || log_w[(base + 1) % 256] !== 8'd4 || done_o !== 1'b1) begin
      fails++; $display("FAIL start_gt_stop: fires=%0d done=%b, expected (40,3),(40,4) done=1",
                        fire_cnt - base, done_o);
    end
  endtask

  task automatic test_delay_overflow();
    int base = fire_cnt;
    set_cfg(16'hFFF0, 16'hFFFF, 8'h20, 8'd5, 8'd5, 8'd1, 8'd1, 16'd0);
    pulse_start();
    wait_idle("overflow", 500);
    tests++;
    if (fire_cnt - base !== 1 || log_d[base % 256] !== 16'hFFF0 || log_w[base % 256] !== 8'd5 ||
        attempts_o !== 24'd1 || done_o !== 1'b1) begin
      fails++; $display("FAIL overflow: fires=%0d attempts=%0d done=%b, expected 1 at (FFF0,5) done=1",
                        fire_cnt - base, attempts_o, done_o);
    end
  endtask

  task automatic test_timeout();
    int base = fire_cnt;
    eng_en = 1'b0;
    set_cfg(16'd1, 16'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 16'd0);
    pulse_start();
    wait_fire("timeout_fire");
    repeat (8) @(negedge clk);
    tests++;
    if (timeout_o !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b, expected 0", timeout_o); end
    @(negedge clk);
    tests++;
    if (timeout_o !== 1'b1) begin fails++; $display("FAIL timeout_set: got %b, expected 1", timeout_o); end
    wait_idle("timeout", 500);
    tests++;
    if (fire_cnt - base !== 2 || done_o !== 1'b1 || timeout_o !== 1'b1 || attempts_o !== 24'd2) begin
      fails++; $display("FAIL timeout_done: fires=%0d done=%b to=%b att=%0d, expected 2/1/1/2",
                        fire_cnt - base, done_o, timeout_o, attempts_o);
    end
    eng_en = 1'b1;
  endtask

  task automatic test_abort();
    set_cfg(16'd0, 16'd100, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 16'd0);
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      wait_fire("abort_fire");
    end
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    tests++;
    if (running_o !== 1'b0 || done_o !== 1'b0 || attempts_o !== 24'd3 || delay_o !== 16'd2) begin
      fails++; $display("FAIL abort: run=%b done=%b att=%0d delay=%0d, expected 0/0/3/2",
                        running_o, done_o, attempts_o, delay_o);
    end
    repeat (10) @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    tests++;
    if (running_o !== 1'b0 || attempts_o !== 24'd3 || fire_o !== 1'b0) begin
      fails++; $display("FAIL abort_wins: run=%b att=%0d, expected 0/3", running_o, attempts_o);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    set_cfg(16'd10, 16'd30, 8'd10, 8'd2, 8'd3, 8'd1, 8'd2, 16'd20);
    pulse_start();
    wait_fire("rst_fire");
    repeat (12) @(negedge clk);
    rst = 1'b1; start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    check_zero_outputs("reset_mid");
    repeat (6) @(negedge clk);
    base = fire_cnt;
    set_cfg(16'd10, 16'd30, 8'd10, 8'd2, 8'd3, 8'd1, 8'd2, 16'd0);
    pulse_start();
    wait_idle("after_reset", 2000);
    check_grid("after_reset", base);
  endtask

  task automatic test_hit();
    int base = fire_cnt;
    set_cfg(16'd10, 16'd30, 8'd10, 8'd2, 8'd3, 8'd1, 8'd2, 16'd1);
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      wait_fire("hit_fire");
    end
    repeat (2) @(negedge clk);
    hit_i = 1'b1;
    @(negedge clk);
    hit_i = 1'b0;
`ifdef SWEEP_STOP_ON_HIT_EN
    tests++;
    if (running_o !== 1'b0 || done_o !== 1'b1 || delay_o !== 16'd20 || width_o !== 8'd2) begin
      fails++; $display("FAIL hit_stop: run=%b done=%b point=(%0d,%0d), expected 0/1/(20,2)",
                        running_o, done_o, delay_o, width_o);
    end
    repeat (40) @(negedge clk);
    tests++;
    if (fire_cnt - base !== 3) begin
      fails++; $display("FAIL hit_no_fire: fires=%0d, expected 3", fire_cnt - base);
    end
`else
    wait_idle("hit_ignored", 2000);
    check_grid("hit_ignored", base);
`endif
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_zero_cfg();
    test_delay_overflow();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_hit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/glitch_sweep_sequencer.md
GLITCH_SWEEP_SEQUENCER -- requirements
Module: glitch_sweep_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_W, default 16, width of settle counter.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start_i  input  1  one-cycle sweep start request.
REQ-005 SHALL have port abort_i  input  1  one-cycle sweep abort request.
REQ-006 SHALL have ports delay_start_i/delay_stop_i  input  16 each  delay range, inclusive.
REQ-007 SHALL have port delay_step_i  input  8  delay increment.
REQ-008 SHALL have ports width_start_i/width_stop_i/width_step_i  input  8 each  width range and increment.
REQ-009 SHALL have port repeats_i  input  8  attempts per (delay,width) point.
REQ-010 SHALL have port settle_i  input  SETTLE_W  idle cycles between attempts.
REQ-011 SHALL have port engine_busy_i  input  1  busy from glitch engine.
REQ-012 SHALL have port hit_i  input  1  fault-observed flag from target monitor.
REQ-013 SHALL have ports delay_o  output  16, width_o  output  8  current point, driven to engine.
REQ-014 SHALL have port fire_o  output  1  one-cycle pulse-enable to engine.
REQ-015 SHALL have ports running_o, done_o, timeout_o  output  1 each  status.
REQ-016 SHALL have port attempts_o  output  24  attempts issued since last start.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, SETTLE, ADVANCE.
REQ-018 IDLE: start_i latches all *_i config into shadow registers, loads delay_o=delay_start, width_o=width_start, clears attempts_o/done_o/timeout_o, goes to ISSUE next cycle.
REQ-019 ISSUE: fire_o=1 for exactly one cycle, attempts_o+1 (saturating at 2^24-1), -> WAIT_BUSY.
REQ-020 WAIT_BUSY: engine_busy_i=1 -> WAIT_DONE; after 8 cycles without busy, set sticky timeout_o and -> SETTLE.
REQ-021 WAIT_DONE: engine_busy_i=0 -> SETTLE; no timeout in this state.
REQ-022 SETTLE: wait settle_i cycles (0 = zero extra cycles), then -> ADVANCE.
REQ-023 ADVANCE order: repeat count innermost, then delay, then width outermost; next point -> ISSUE, sweep exhausted -> IDLE with done_o=1.
REQ-024 repeats_i=0 SHALL behave as 1.
REQ-025 step value 0 SHALL behave as 1.
REQ-026 Delay advance SHALL compute in 17 bits; if delay+step > delay_stop or overflows, delay wraps to delay_start and width advances.
REQ-027 Width advance SHALL compute in 9 bits; if width+step > width_stop or overflows, sweep is exhausted.
REQ-028 start > stop on either axis SHALL yield single point at start value on that axis.
REQ-029 abort_i in any non-IDLE state SHALL -> IDLE next cycle, done_o stays 0, delay_o/width_o hold; engine pulse in flight is not cancelled.
REQ-030 abort_i and start_i same cycle in IDLE: abort wins, no sweep.
REQ-031 start_i while not IDLE SHALL be ignored.
REQ-032 running_o SHALL be 1 in every state except IDLE.
REQ-033 done_o SHALL stay set until next accepted start_i or reset.
REQ-034 Config inputs SHALL be ignored during a sweep; shadows only are used.

Reset
REQ-035 rst SHALL force IDLE and zero delay_o, width_o, fire_o, running_o, done_o, timeout_o, attempts_o, all counters and shadows.
REQ-036 rst mid-sweep SHALL take effect next edge, overriding abort_i/start_i.

Configuration
REQ-037 Macro SWEEP_STOP_ON_HIT_EN defined: hit_i=1 sampled in WAIT_DONE or SETTLE -> IDLE with done_o=1, delay_o/width_o frozen at hitting point, no further fire_o.
REQ-038 Macro SWEEP_STOP_ON_HIT_EN undefined: hit_i SHALL be ignored and sweep runs to exhaustion.

Verification
REQ-039 delay 10..30 step 10, width 2..3 step 1, repeats 2, engine model busy 5 cycles -> 12 fire_o pulses, points (10,2)x2,(20,2)x2,(30,2)x2,(10,3)x2..(30,3)x2, attempts_o=12, done_o=1.
REQ-040 delay_start=0xFFF0 stop=0xFFFF step 0x20, width 5..5 -> single attempt at (0xFFF0,5), no wrap-around error, done_o=1.
REQ-041 engine_busy_i tied 0 -> timeout_o=1 after 8 cycles in WAIT_BUSY, sweep still completes.
REQ-042 abort_i asserted 2 cycles after third fire_o -> running_o=0 next cycle, done_o=0, attempts_o=3.
REQ-043 With SWEEP_STOP_ON_HIT_EN, hit_i pulsed during WAIT_DONE of attempt at (20,2) -> done_o=1, delay_o=20, width_o=2, no further fire_o.
REQ-044 rst asserted in SETTLE -> all outputs zero next cycle; subsequent start_i runs full sweep from start values.
